serial_addsub_ctrl: RTL
=======================

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-006 SHALL have port a  input  WIDTH  first operand.
REQ-007 SHALL have port b  input  WIDTH  second operand.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (state != IDLE).
REQ-009 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-010 SHALL have port result  output  WIDTH  sum/difference, LSB-first assembled.
REQ-011 SHALL have port cout  output  1  final carry (subtract: 1 = no borrow).
REQ-012 SHALL have port overflow  output  1  signed two's-complement overflow flag.

Function
REQ-013 SHALL compute one bit per clock through a single one-bit add/sub cell instance: sum = a_i^b_i^op^c, carry = a_i&(b_i^op) | (b_i^op)&c | c&a_i.
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after WIDTH bit cycles, DONE->IDLE unconditionally after one cycle.
REQ-015 On the edge sampling start in IDLE, SHALL latch a, b, op into internal shift registers, load carry register with op, clear bit counter to 0.
REQ-016 In RUN, each edge SHALL process bit index = counter (LSB first), shift sum into result MSB side, update carry register, increment counter.
REQ-017 SHALL transition RUN->DONE on the edge processing bit WIDTH-1; counter SHALL never exceed WIDTH-1.
REQ-018 Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH, for exactly one cycle.
REQ-019 result, cout, overflow SHALL be stable from done until the edge that accepts the next start.
REQ-020 start SHALL be ignored while in RUN or DONE; operand changes during RUN SHALL not affect the result.
REQ-021 Back-to-back: start held high SHALL launch the next operation on the first IDLE edge after DONE (one idle cycle minimum between done pulses).
REQ-022 cout SHALL equal the carry out of bit WIDTH-1; for subtract, cout=1 iff a >= b unsigned.
REQ-023 result SHALL be (a + b) mod 2^WIDTH or (a - b) mod 2^WIDTH.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, cout=0, overflow=0, counter=0, carry register=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst_n release SHALL behave as from power-up.
REQ-026 Reset deassertion SHALL be the only event needed; no start SHALL be accepted while rst_n is low.

Configuration
REQ-027 Macro SERIAL_ADDSUB_OVF_EN defined: SHALL capture carry into bit WIDTH-1 and drive overflow = carry_in_msb ^ cout, updated with result.
REQ-028 Macro SERIAL_ADDSUB_OVF_EN undefined: overflow SHALL be tied to 0 and the MSB-carry capture register SHALL not be present; all other behaviour unchanged.

Verification (WIDTH=8)
REQ-029 Add 0x05+0x03, start at edge k -> done at cycle after edge k+8, result=0x08, cout=0, overflow=0.
REQ-030 Add 0xFF+0x01 -> result=0x00, cout=1, overflow=0.
REQ-031 Subtract 0x05-0x07 -> result=0xFE, cout=0; subtract 0x07-0x05 -> result=0x02, cout=1.
REQ-032 With SERIAL_ADDSUB_OVF_EN: add 0x7F+0x01 -> result=0x80, overflow=1; subtract 0x80-0x01 -> result=0x7F, overflow=1; without macro both give overflow=0.
REQ-033 Pulse start again during RUN with different operands -> ignored, first operation's result delivered, single done pulse.
REQ-034 Drop rst_n at bit 4 of an operation -> busy=0, result=0 immediately, no done pulse; next start computes 0x10+0x20 = 0x30 correctly.

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial adder/subtractor, one bit per clock, LSB first.
// A single one-bit add/sub cell is time-multiplexed over the operand bits.
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN
//   defined   -> signed overflow flag, from a captured carry into the MSB
//   undefined -> overflow tied low and the MSB-carry register is not built

// One-bit add/sub cell; subtract inverts b and relies on carry-in = 1 from the controller.
module serial_addsub_cell (
   input  logic a,
   input  logic b,
   input  logic op,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic b_eff;

   assign b_eff = b ^ op;
   assign sum   = a ^ b_eff ^ cin;
   assign cout  = (a & b_eff) | (b_eff & cin) | (cin & a);

endmodule

module serial_addsub_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  result_q;
   logic [CntW-1:0]   cnt_q;
   logic              op_q;
   logic              carry_q;
   logic              cout_q;
   logic              busy_q;
   logic              done_q;

   logic              bit_sum;
   logic              bit_carry;
   logic              last_bit;

   // Operand registers shift right, so the bit at index cnt_q always sits at position 0.
   serial_addsub_cell u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .op   (op_q),
      .cin  (carry_q),
      .sum  (bit_sum),
      .cout (bit_carry)
   );

   assign last_bit = (cnt_q == LastIdx);

   // Controller FSM: operand capture, per-bit datapath update and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= op;
                  // Carry-in of 1 completes the two's-complement negation of b.
                  carry_q <= op;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               result_q <= {bit_sum, result_q[WIDTH-1:1]};
               carry_q  <= bit_carry;
               if (last_bit) begin
                  // Counter parks at WIDTH-1; it is cleared when the next start is taken.
                  cout_q  <= bit_carry;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;

`ifdef SERIAL_ADDSUB_OVF_EN
   logic msb_carry_q;

   // Capture the carry into the MSB on the same edge that produces the final carry-out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msb_carry_q <= 1'b0;
      end else if ((state_q == StRun) && last_bit) begin
         msb_carry_q <= carry_q;
      end
   end

   assign overflow = msb_carry_q ^ cout_q;
`else
   assign overflow = 1'b0;
`endif

endmodule
